// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: drives datapath selects/strobes, shares one memory port.
// Define MIPS_CTRL_ADDI_EN to decode addi (opcode 0x08); otherwise 0x08 halts as illegal.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10
`ifdef MIPS_CTRL_ADDI_EN
    ,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'h08;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halted_q, halted_d;
  logic [5:0]         op_q, op_d;
  logic               retire;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    op_d     = (state_q == S_DECODE) ? op_code : op_q;
    retire   = 1'b0;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default:      state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: retire = mem_ready;
      S_EXECUTE:   state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH: retire = 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ADDI_WB:   retire = 1'b1;
`endif
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
    // A finished instruction always returns through FETCH or parks in IDLE.
    if (retire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = run ? S_FETCH : S_IDLE;
    end
    if (state_d == S_HALT) halted_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  // Opcode is held past DECODE so MEM_ADDR can pick load vs store.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:   reg_write = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state         = state_q;
  assign halted        = halted_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: vector table through a scoreboard queue, plus reset/halt/wrap/addi sequences.
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset, run, mem_ready;
  logic [5:0] op_code;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic halted;
  logic [CNT_W-1:0] retired_count;
  logic [15:0] ctl;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .halted(halted),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  typedef struct {
    logic             run;
    logic [5:0]       op;
    logic             rdy;
    logic [3:0]       st;
    logic [15:0]      ctl;
    logic [CNT_W-1:0] cnt;
    logic             hlt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int total = 0;
  int passed = 0;
  int step_no = 0;

  logic [15:0] c_idle, c_fr, c_fw, c_dec, c_ma, c_mr, c_mwb, c_mw, c_ex, c_rwb, c_br, c_aex, c_awb;

  function automatic logic [15:0] mk(input logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa,
                                     input logic [1:0] asb, aop, ps);
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic [5:0] o, input logic rd, input logic [3:0] s,
                     input logic [15:0] c, input int cnt, input logic h);
    vec_t v;
    v.run = r; v.op = o; v.rdy = rd; v.st = s; v.ctl = c; v.cnt = CNT_W'(cnt); v.hlt = h;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, queue the expectation, compare after settling, advance one edge.
  task automatic apply(input vec_t v);
    vec_t e;
    run = v.run; op_code = v.op; mem_ready = v.rdy;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    check($sformatf("s%0d state", step_no), 32'(state), 32'(e.st));
    check($sformatf("s%0d ctl", step_no), 32'(ctl), 32'(e.ctl));
    check($sformatf("s%0d count", step_no), 32'(retired_count), 32'(e.cnt));
    check($sformatf("s%0d halted", step_no), 32'(halted), 32'(e.hlt));
    step_no++;
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic rd, input logic [3:0] s,
                      input logic [15:0] c, input int cnt, input logic h);
    vec_t v;
    v.run = r; v.op = o; v.rdy = rd; v.st = s; v.ctl = c; v.cnt = CNT_W'(cnt); v.hlt = h;
    apply(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //            pw pwc iod mr mw irw m2r rd rw asa asb   aop   ps
    c_idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    c_fr   = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    c_fw   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    c_dec  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    c_ma   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    c_mr   = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    c_mwb  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    c_mw   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    c_ex   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
    c_rwb  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
    c_br   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
    c_aex  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    c_awb  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);

    // lw, all ready
    add(1, 6'h23, 1, 0, c_idle, 0, 0);
    add(1, 6'h23, 1, 1, c_fr,   0, 0);
    add(1, 6'h23, 1, 2, c_dec,  0, 0);
    add(1, 6'h23, 1, 3, c_ma,   0, 0);
    add(1, 6'h23, 1, 4, c_mr,   0, 0);
    add(1, 6'h23, 1, 5, c_mwb,  0, 0);
    // sw with three wait cycles in MEM_WRITE
    add(1, 6'h2B, 1, 1, c_fr,   1, 0);
    add(1, 6'h2B, 1, 2, c_dec,  1, 0);
    add(1, 6'h2B, 1, 3, c_ma,   1, 0);
    add(1, 6'h2B, 0, 6, c_mw,   1, 0);
    add(1, 6'h2B, 0, 6, c_mw,   1, 0);
    add(1, 6'h2B, 0, 6, c_mw,   1, 0);
    add(1, 6'h2B, 1, 6, c_mw,   1, 0);
    // R-type with one fetch wait, then beq with run dropped in BRANCH
    add(1, 6'h00, 0, 1, c_fw,   2, 0);
    add(1, 6'h00, 1, 1, c_fr,   2, 0);
    add(1, 6'h00, 1, 2, c_dec,  2, 0);
    add(1, 6'h00, 1, 7, c_ex,   2, 0);
    add(1, 6'h00, 1, 8, c_rwb,  2, 0);
    add(1, 6'h04, 1, 1, c_fr,   3, 0);
    add(1, 6'h04, 1, 2, c_dec,  3, 0);
    add(0, 6'h04, 1, 9, c_br,   3, 0);
    add(0, 6'h23, 1, 0, c_idle, 4, 0);
    // lw with a MEM_READ wait, run dropped in MEM_WB
    add(1, 6'h23, 1, 0, c_idle, 4, 0);
    add(1, 6'h23, 1, 1, c_fr,   4, 0);
    add(1, 6'h23, 1, 2, c_dec,  4, 0);
    add(1, 6'h23, 1, 3, c_ma,   4, 0);
    add(1, 6'h23, 0, 4, c_mr,   4, 0);
    add(1, 6'h23, 1, 4, c_mr,   4, 0);
    add(0, 6'h23, 1, 5, c_mwb,  4, 0);
    // illegal opcode
    add(1, 6'h3F, 1, 0, c_idle, 5, 0);
    add(1, 6'h3F, 1, 1, c_fr,   5, 0);
    add(1, 6'h3F, 1, 2, c_dec,  5, 0);
    add(1, 6'h3F, 1, 10, c_idle, 5, 1);

    reset = 1'b1; run = 1'b0; op_code = 6'h00; mem_ready = 1'b0;
    @(negedge clk);
    check("reset state", 32'(state), 32'd0);
    check("reset ctl", 32'(ctl), 32'd0);
    check("reset count", 32'(retired_count), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // HALT ignores run for 20 cycles
    for (int i = 0; i < 20; i++) step(1, 6'h23, 1, 10, c_idle, 5, 1);

    reset = 1'b1;
    #1;
    check("halt reset state", 32'(state), 32'd0);
    check("halt reset halted", 32'(halted), 32'd0);
    check("halt reset count", 32'(retired_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // R-type retires once, then lw is aborted by reset in MEM_READ
    step(1, 6'h00, 1, 0, c_idle, 0, 0);
    step(1, 6'h00, 1, 1, c_fr,   0, 0);
    step(1, 6'h00, 1, 2, c_dec,  0, 0);
    step(1, 6'h00, 1, 7, c_ex,   0, 0);
    step(1, 6'h23, 1, 8, c_rwb,  0, 0);
    step(1, 6'h23, 1, 1, c_fr,   1, 0);
    step(1, 6'h23, 1, 2, c_dec,  1, 0);
    step(1, 6'h23, 1, 3, c_ma,   1, 0);
    step(1, 6'h23, 0, 4, c_mr,   1, 0);
    reset = 1'b1; run = 1'b0;
    #1;
    check("abort state", 32'(state), 32'd0);
    check("abort count", 32'(retired_count), 32'd0);
    check("abort ctl", 32'(ctl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 6'h23, 1, 0, c_idle, 0, 0);

    // 16 beq retirements wrap the 4-bit counter
    step(1, 6'h04, 1, 0, c_idle, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(1, 6'h04, 1, 1, c_fr,  k & 15, 0);
      step(1, 6'h04, 1, 2, c_dec, k & 15, 0);
      step(1, 6'h04, 1, 9, c_br,  k & 15, 0);
    end
    step(1, 6'h08, 1, 1, c_fr,  0, 0);
    step(1, 6'h08, 1, 2, c_dec, 0, 0);
`ifdef MIPS_CTRL_ADDI_EN
    step(1, 6'h08, 1, 11, c_aex, 0, 0);
    step(1, 6'h08, 1, 12, c_awb, 0, 0);
    step(1, 6'h08, 1, 1, c_fr,   1, 0);
`else
    step(1, 6'h08, 1, 10, c_idle, 0, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style multi-cycle control sequencer for the MIPS datapath: it turns the single-cycle datapath into a 3–5 cycle-per-instruction machine that shares one memory port between fetch and load/store. It sits beside the register file, ALU and memory, takes the latched opcode from the instruction register, and drives every mux select, write enable and ALU-op line. A memory wait-state handshake, a run/idle gate, an illegal-opcode halt and a retired-instruction counter are included.

## Interface
- CNT_W, 16, width of retired_count
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- run  in  1  level; permits fetching a new instruction
- op_code  in  6  IR[31:26], sampled in DECODE
- mem_ready  in  1  memory access completes this cycle
- pc_write, pc_write_cond  out  1  unconditional / branch PC write enables
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read, mem_write, ir_write  out  1  memory read/write strobes, IR load
- mem_to_reg, reg_dst, reg_write  out  1  register write-back controls
- alu_src_a  out  1  0=PC, 1=A register
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  to ALU_Controller: 00=add, 01=sub, 10=funct field
- pc_source  out  2  00=ALU result, 01=ALUOut
- state  out  4  current state encoding
- halted  out  1  sticky illegal-opcode flag
- retired_count  out  CNT_W  instructions completed

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, R_WB 8, BRANCH 9, HALT 10, ADDI_EX 11, ADDI_WB 12.
- IDLE: all controls 0; run=1 -> FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; mem_ready=1 -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Opcode dispatch: 0x23/0x2B -> MEM_ADDR, 0x00 -> EXECUTE, 0x04 -> BRANCH, 0x08 -> ADDI_EX (macro only), any other opcode -> HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for lw (0x23) and to MEM_WRITE for sw (0x2B).
- MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEM_WRITE: mem_write=1, i_or_d=1. Held until mem_ready=1; the instruction completes in the mem_ready cycle.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
- Completion states are MEM_WB, MEM_WRITE (with mem_ready), R_WB, BRANCH and ADDI_WB. On leaving one: retired_count += 1, wrapping at 2^CNT_W; next state is FETCH if run=1, else IDLE.
- HALT: all controls 0 and halted=1. Left only by reset; run is ignored.
- run deasserted mid-instruction: the current instruction completes, then the block enters IDLE.
- Control outputs not listed for a state are 0.

## Timing
- Reset: state=IDLE, retired_count=0, halted=0, all control outputs 0; takes effect immediately.
- Control outputs are combinational from the state register; the exceptions are ir_write and pc_write in FETCH, which also depend on mem_ready.
- Latency with mem_ready tied to 1, FETCH to the next FETCH: lw 5, sw 4, R-type 4, beq 3, addi 4 cycles.
- Each low cycle of mem_ready adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- IDLE with run=1 enters FETCH on the next edge.
- Reset mid-instruction aborts the instruction with no retire and no write strobe.
- retired_count increments on the clock edge that leaves a completion state.

## Configuration
- MIPS_CTRL_ADDI_EN defined: opcode 0x08 is decoded and sequences DECODE -> ADDI_EX -> ADDI_WB.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- MIPS_CTRL_ADDI_EN undefined: ADDI_EX and ADDI_WB do not exist; 0x08 is illegal -> HALT.

## Test plan
- run=1, mem_ready=1, op_code=0x23: state sequence 1,2,3,4,5,1; reg_write and mem_to_reg high only in state 5; retired_count=1 after 5 cycles.
- op_code=0x2B with mem_ready low for 3 cycles in MEM_WRITE: mem_write held 4 cycles; retired_count increments once; no reg_write.
- op_code=0x00 then 0x04: R-type shows alu_op=10 in EXECUTE and reg_dst=1 in R_WB; beq shows pc_write_cond=1, pc_source=01, alu_op=01; 7 cycles total.
- op_code=0x3F: DECODE -> HALT; halted=1 and all controls stay 0 for 20 cycles with run=1; reset clears halted.
- Assert reset during MEM_READ: state=0 immediately, retired_count=0; run=0 after reset keeps IDLE.
- Preset retired_count to all-ones (CNT_W=4, 15 instructions), retire one more: count wraps to 0. With MIPS_CTRL_ADDI_EN, op 0x08 gives states 11, 12.
